// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage data-memory access unit.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [31:0] DATA_BASE_DEFAULT = 32'h1001_0000;
    localparam logic [31:0] TIMEOUT_FILL      = 32'hDEAD_BEEF;
    localparam int          MAX_WAIT_DEFAULT  = 15;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for a pending bus access; flags the last permitted wait cycle.
module mem_wait_timer
    import mem_access_unit_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic last
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] count;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    // High while the increment taken this cycle would bring the count to MAX_WAIT.
    assign last = (count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: turns lw/sw into a req/ack bus transaction and stalls the
// pipeline until the access completes or times out.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter logic [31:0] DATA_BASE = DATA_BASE_DEFAULT,
    parameter int          ADDR_W    = 10,
    parameter int          MAX_WAIT  = MAX_WAIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [31:0]       bus_rdata_i,
    output logic [31:0]       read_data_o,
    output logic              stall_o,
    output logic              enable_mem_wb_o,
    output logic              err_o
);

    state_t      state;
    logic        op;
    logic        both;
    logic        addr_ok;
    logic        wait_last;
    logic [31:0] offset;

    assign op     = mem_read_i | mem_write_i;
    assign both   = mem_read_i & mem_write_i;
    assign offset = addr_i - DATA_BASE;

    // DATA_BASE is word aligned, so offset[1:0] equals addr_i[1:0].
    assign addr_ok = (offset[1:0] == 2'b00) && (addr_i >= DATA_BASE)
                     && (offset[31:ADDR_W+2] == '0);

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk   (clk),
        .reset (reset),
        .clear (state == IDLE),
        .inc   ((state == ACCESS) && !bus_ack_i),
        .last  (wait_last)
    );

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            read_data_o <= '0;
            err_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op) begin
                        if (both) begin
                            err_o <= 1'b1;
                        end
                        if (addr_ok) begin
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= mem_write_i;
                            bus_addr_o  <= offset[ADDR_W+1:2];
                            bus_wdata_o <= wdata_i;
                            state       <= ACCESS;
                        end else begin
                            err_o <= 1'b1;
                            if (!mem_write_i) begin
                                read_data_o <= '0;
                            end
                        end
                    end
                end
                ACCESS: begin
                    // An ack in the final wait cycle wins over the timeout.
                    if (bus_ack_i) begin
                        if (!bus_we_o) begin
                            read_data_o <= bus_rdata_i;
                        end
                        bus_req_o <= 1'b0;
                        state     <= DONE;
                    end else if (wait_last) begin
                        if (!bus_we_o) begin
                            read_data_o <= TIMEOUT_FILL;
                        end
                        bus_req_o <= 1'b0;
                        err_o     <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Gated by reset so upstream stages see no stall while reset is held.
    assign stall_o = reset && (((state == IDLE) && op && addr_ok) || (state == ACCESS));
    assign enable_mem_wb_o = ~stall_o;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table for the main flows plus
// hand-written sequences for errors, timeout boundary and mid-access reset.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [9:0]  bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic [31:0] read_data_o;
    logic        stall_o;
    logic        enable_mem_wb_o;
    logic        err_o;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_unit dut (
        .clk             (clk),
        .reset           (reset),
        .mem_read_i      (mem_read_i),
        .mem_write_i     (mem_write_i),
        .addr_i          (addr_i),
        .wdata_i         (wdata_i),
        .bus_req_o       (bus_req_o),
        .bus_we_o        (bus_we_o),
        .bus_addr_o      (bus_addr_o),
        .bus_wdata_o     (bus_wdata_o),
        .bus_ack_i       (bus_ack_i),
        .bus_rdata_i     (bus_rdata_i),
        .read_data_o     (read_data_o),
        .stall_o         (stall_o),
        .enable_mem_wb_o (enable_mem_wb_o),
        .err_o           (err_o)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ack;
        logic [31:0] rdata_in;
        logic        e_stall;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_baddr;
        logic [31:0] e_bwdata;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        mem_read_i  = rd;
        mem_write_i = wr;
        addr_i      = a;
        wdata_i     = d;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h0;
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        reset = 1'b1;
    endtask

    // Issues one memory op starting in the next cycle; the bus model acks after
    // 'waits' unacknowledged ACCESS cycles. Returns at mid-cycle of the first
    // non-stalled cycle (DONE for a bus op, the IDLE cycle itself otherwise).
    task automatic mem_op(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input int waits, input logic [31:0] rdat,
                          output int stalls);
        int  acc;
        bit  done;
        acc    = 0;
        stalls = 0;
        done   = 0;
        @(negedge clk);
        #1;
        drive(rd, wr, a, d);
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk);
            #1;
            if (!stall_o) begin
                done = 1;
            end else begin
                stalls++;
                @(negedge clk);
                #1;
                bus_ack_i   = bus_req_o && (acc == waits);
                bus_rdata_i = bus_ack_i ? rdat : 32'h0;
                if (bus_req_o) acc++;
            end
        end
        bus_ack_i = 1'b0;
        if (!done) chk("op_completes", 32'(stalls), 32'd0);
    endtask

    initial begin
        int st;

        vecs[0]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,         32'h0,         1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h1001_0008, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,   32'h0,         32'h0,         1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h1001_0008, 32'h0, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 32'h2,   32'h0,         32'h0,         1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h1001_0008, 32'h0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,   32'h0,         32'h1234_5678, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h1001_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,         32'h1234_5678, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'h1001_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h3FF, 32'hCAFE_F00D, 32'h1234_5678, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h1001_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h3FF, 32'hCAFE_F00D, 32'h1234_5678, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h1001_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h3FF, 32'hCAFE_F00D, 32'h1234_5678, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h1001_0FFC, 32'hCAFE_F00D, 1'b1, 32'h5555_AAAA, 1'b1, 1'b1, 1'b1, 32'h3FF, 32'hCAFE_F00D, 32'h1234_5678, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h1001_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,         32'h1234_5678, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h0000_1234, 32'h0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,   32'h0,         32'h1234_5678, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h1001_0000, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,   32'h0,         32'h1234_5678, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'h1001_0000, 32'h0, 1'b1, 32'hA5A5_0F0F, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0,         32'h1234_5678, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 32'h1001_0000, 32'h0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,   32'h0,         32'hA5A5_0F0F, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 32'h1001_0004, 32'h0BAD_CAFE, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,         32'hA5A5_0F0F, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 32'h1001_0004, 32'h0BAD_CAFE, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 32'h1,   32'h0BAD_CAFE, 32'hA5A5_0F0F, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 32'h1001_0004, 32'h0BAD_CAFE, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,         32'hA5A5_0F0F, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,   32'h0,         32'hA5A5_0F0F, 1'b0};

        // Reset values
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h0;
        #12;
        chk("rst_req", 32'(bus_req_o), 32'd0);
        chk("rst_we", 32'(bus_we_o), 32'd0);
        chk("rst_addr", 32'(bus_addr_o), 32'd0);
        chk("rst_wdata", bus_wdata_o, 32'd0);
        chk("rst_rdata", read_data_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        @(posedge clk);
        reset = 1'b1;
        #1;
        chk("rst_stall", 32'(stall_o), 32'd0);

        // Main flows from the vector table
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            #1;
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            bus_ack_i   = vecs[i].ack;
            bus_rdata_i = vecs[i].rdata_in;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_stall", i), 32'(stall_o), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_en", i), 32'(enable_mem_wb_o), 32'(!vecs[i].e_stall));
            chk($sformatf("v%0d_req", i), 32'(bus_req_o), 32'(vecs[i].e_req));
            chk($sformatf("v%0d_rdata", i), read_data_o, vecs[i].e_rdata);
            chk($sformatf("v%0d_err", i), 32'(err_o), 32'(vecs[i].e_err));
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d_we", i), 32'(bus_we_o), 32'(vecs[i].e_we));
                chk($sformatf("v%0d_baddr", i), 32'(bus_addr_o), vecs[i].e_baddr);
                chk($sformatf("v%0d_bwdata", i), bus_wdata_o, vecs[i].e_bwdata);
            end
        end

        // Misaligned read: no bus cycle, no stall, err set, read data cleared
        mem_op(1'b1, 1'b0, 32'h1001_0002, 32'h0, 0, 32'h0, st);
        chk("misal_stalls", 32'(st), 32'd0);
        chk("misal_req", 32'(bus_req_o), 32'd0);
        @(negedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk("misal_err", 32'(err_o), 32'd1);
        chk("misal_rdata", read_data_o, 32'h0);
        chk("misal_req2", 32'(bus_req_o), 32'd0);

        // Out-of-range read after a fresh reset and a good load
        do_reset();
        mem_op(1'b1, 1'b0, 32'h1001_0020, 32'h0, 0, 32'h1111_2222, st);
        chk("lw20_stalls", 32'(st), 32'd2);
        chk("lw20_rdata", read_data_o, 32'h1111_2222);
        chk("lw20_err", 32'(err_o), 32'd0);
        mem_op(1'b1, 1'b0, 32'h1001_1000, 32'h0, 0, 32'h0, st);
        chk("oor_stalls", 32'(st), 32'd0);
        chk("oor_req", 32'(bus_req_o), 32'd0);
        @(negedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk("oor_err", 32'(err_o), 32'd1);
        chk("oor_rdata", read_data_o, 32'h0);
        mem_op(1'b1, 1'b0, 32'h1000_FFFC, 32'h0, 0, 32'h0, st);
        chk("below_stalls", 32'(st), 32'd0);
        mem_op(1'b1, 1'b0, 32'h1001_0FFC, 32'h0, 1, 32'h3333_4444, st);
        chk("sticky_stalls", 32'(st), 32'd3);
        chk("sticky_rdata", read_data_o, 32'h3333_4444);
        chk("sticky_err", 32'(err_o), 32'd1);

        // Read and write together: performed as a write, err set
        do_reset();
        mem_op(1'b1, 1'b1, 32'h1001_0040, 32'h0000_0077, 0, 32'h9999_9999, st);
        chk("rw_stalls", 32'(st), 32'd2);
        chk("rw_we", 32'(bus_we_o), 32'd1);
        chk("rw_baddr", 32'(bus_addr_o), 32'h10);
        chk("rw_wdata", bus_wdata_o, 32'h77);
        chk("rw_rdata", read_data_o, 32'h0);
        chk("rw_err", 32'(err_o), 32'd1);

        // Ack in the last permitted wait cycle succeeds
        do_reset();
        mem_op(1'b1, 1'b0, 32'h1001_0010, 32'h0, 14, 32'h0F0F_F0F0, st);
        chk("lastack_stalls", 32'(st), 32'd16);
        chk("lastack_rdata", read_data_o, 32'h0F0F_F0F0);
        chk("lastack_err", 32'(err_o), 32'd0);

        // Ack never arrives: timeout
        mem_op(1'b1, 1'b0, 32'h1001_0010, 32'h0, 15, 32'h0, st);
        chk("tmo_stalls", 32'(st), 32'd16);
        chk("tmo_rdata", read_data_o, 32'hDEAD_BEEF);
        chk("tmo_err", 32'(err_o), 32'd1);
        chk("tmo_req", 32'(bus_req_o), 32'd0);

        // Reset pulled during ACCESS
        @(negedge clk);
        #1;
        drive(1'b1, 1'b0, 32'h1001_0030, 32'h0);
        @(negedge clk);
        #1;
        chk("mid_req_before", 32'(bus_req_o), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_req", 32'(bus_req_o), 32'd0);
        chk("mid_stall", 32'(stall_o), 32'd0);
        chk("mid_rdata", read_data_o, 32'h0);
        chk("mid_err", 32'(err_o), 32'd0);
        @(posedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        mem_op(1'b1, 1'b0, 32'h1001_0030, 32'h0, 0, 32'h600D_F00D, st);
        chk("post_stalls", 32'(st), 32'd2);
        chk("post_rdata", read_data_o, 32'h600D_F00D);
        chk("post_err", 32'(err_o), 32'd0);
        chk("post_en", 32'(enable_mem_wb_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
